// File: rtl/cnn_header_reader_pkg.sv
// Shared definitions for the CNN header reader: header word offsets, FSM states
// and the header-length helper.
package cnn_header_reader_pkg;

    localparam int HDR_FS  = 0;
    localparam int HDR_N   = 1;
    localparam int HDR_FO  = 2;
    localparam int HDR_DO  = 3;
    localparam int HDR_CNT = 4;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_CAPT       = 3'd2,
        S_CHECK      = 3'd3,
        S_EMIT_CONV  = 3'd4,
        S_EMIT_DENSE = 3'd5,
        S_DONE       = 3'd6,
        S_ERR        = 3'd7
    } state_t;

    function automatic int unsigned hdr_len(input int unsigned n);
        return 4 * n + 2;
    endfunction

endpackage

// File: rtl/cnn_header_reader_acc.sv
// Running base-address accumulator: loads an absolute base, then advances by the
// size of each layer handed out (conv: a + a*fs*fs, dense: a + b).
module layer_base_acc #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          RST_n,
    input  logic          mode,
    input  logic [DW-1:0] fs,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          load,
    input  logic          step,
    output logic [DW-1:0] base
);

    logic [DW-1:0] acc_q;
    logic [DW-1:0] acc_d;
    logic [DW-1:0] size;

    always_comb begin
        size  = mode ? (a + b) : (a + a * fs * fs);
        acc_d = acc_q;
        if (load) begin
            acc_d = a;
        end else if (step) begin
            acc_d = acc_q + size;
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign base = acc_q;

endmodule

// File: rtl/cnn_header_reader.sv
// Reads the CNN parameter header out of RAM, validates its offsets and streams
// per-layer conv/dense descriptors with absolute parameter base addresses.
module cnn_header_reader
    import cnn_header_reader_pkg::*;
#(
    parameter int MAX_LAYERS = 10,
    parameter int AW         = 16,
    parameter int DW         = 16
) (
    input  logic          clk,
    input  logic          RST_n,
    input  logic          start,
    output logic [AW-1:0] ramAddress,
    output logic          readSignal,
    input  logic [DW-1:0] ramDataOut,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [DW-1:0] filter_size,
    output logic [DW-1:0] num_layers,
    output logic          desc_valid,
    input  logic          desc_ready,
    output logic          desc_dense,
    output logic [3:0]    desc_index,
    output logic [DW-1:0] desc_count,
    output logic [DW-1:0] desc_aux,
    output logic [AW-1:0] desc_base
);

    localparam int HL = 4 * MAX_LAYERS + 2;
    localparam int IW = $clog2(HL);
    localparam logic [IW-1:0] CNT_I = IW'(HDR_CNT);

    state_t        state_q, state_d;
    logic [IW-1:0] k_q, k_d;
    logic [3:0]    idx_q, idx_d;
    logic [DW-1:0] fs_q, fs_d;
    logic [DW-1:0] n_q, n_d;
    logic [DW-1:0] hdr_q [HL];
    logic          hdr_we;

    logic          acc_load, acc_step, acc_mode;
    logic [DW-1:0] ld_val, acc_a, acc_b, acc_base;

    logic [DW-1:0] len_w;
    logic          n_ok, check_ok;
    logic [IW-1:0] n_lo, ii, cnt_i, typ_i, nd_i, nw_i;

    assign len_w = DW'(hdr_len(32'(n_q)));
    assign n_ok  = (ramDataOut != '0) && (ramDataOut <= DW'(MAX_LAYERS));

    // Prefix chain of conv block sizes; only the first N layers contribute.
    logic [DW-1:0] conv_pref [MAX_LAYERS+1];
    assign conv_pref[0] = '0;
    for (genvar gi = 0; gi < MAX_LAYERS; gi++) begin : g_conv_sum
        assign conv_pref[gi+1] = conv_pref[gi] + ((DW'(gi) < n_q)
            ? (hdr_q[HDR_CNT+gi] + hdr_q[HDR_CNT+gi] * fs_q * fs_q) : '0);
    end

    assign check_ok = (hdr_q[HDR_FO] == len_w) &&
                      (hdr_q[HDR_DO] == hdr_q[HDR_FO] + conv_pref[MAX_LAYERS]);

    assign n_lo  = n_q[IW-1:0];
    assign ii    = IW'(idx_q);
    assign cnt_i = CNT_I + ii;
    assign typ_i = CNT_I + n_lo + ii;
    assign nd_i  = CNT_I + (n_lo << 1) + (ii << 1);
    assign nw_i  = nd_i + IW'(1);

    always_comb begin
        desc_valid = 1'b0;
        desc_dense = 1'b0;
        desc_index = '0;
        desc_count = '0;
        desc_aux   = '0;
        desc_base  = '0;
        if (state_q == S_EMIT_CONV) begin
            desc_valid = 1'b1;
            desc_index = idx_q;
            desc_count = hdr_q[cnt_i];
            desc_aux   = hdr_q[typ_i];
            desc_base  = AW'(acc_base);
        end else if (state_q == S_EMIT_DENSE) begin
            desc_valid = 1'b1;
            desc_dense = 1'b1;
            desc_index = idx_q;
            desc_count = hdr_q[nd_i];
            desc_aux   = hdr_q[nw_i];
            desc_base  = AW'(acc_base);
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        idx_d    = idx_q;
        fs_d     = fs_q;
        n_d      = n_q;
        hdr_we   = 1'b0;
        acc_load = 1'b0;
        acc_step = 1'b0;
        ld_val   = '0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d  = S_FETCH;
                    k_d      = '0;
                    idx_d    = '0;
                    fs_d     = '0;
                    n_d      = '0;
                    acc_load = 1'b1;
                end
            end
            S_FETCH: state_d = S_CAPT;
            S_CAPT: begin
                hdr_we = 1'b1;
                k_d    = k_q + IW'(1);
                if (k_q == IW'(HDR_FS)) fs_d = ramDataOut;
                if (k_q == IW'(HDR_N))  n_d  = ramDataOut;
                // A bad layer count aborts before any further reads.
                if (k_q == IW'(HDR_N) && !n_ok) begin
                    state_d = S_ERR;
                end else if (k_q <= IW'(HDR_N) || (DW'(k_q) + DW'(1)) < len_w) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (check_ok) begin
                    state_d  = S_EMIT_CONV;
                    idx_d    = '0;
                    acc_load = 1'b1;
                    ld_val   = hdr_q[HDR_FO];
                end else begin
                    state_d = S_ERR;
                end
            end
            S_EMIT_CONV: begin
                if (desc_ready) begin
                    idx_d = idx_q + 4'd1;
                    if (DW'(idx_q) + DW'(1) == n_q) begin
                        idx_d    = '0;
                        acc_load = 1'b1;
                        ld_val   = hdr_q[HDR_DO];
                        state_d  = (n_q == DW'(1)) ? S_DONE : S_EMIT_DENSE;
                    end else begin
                        acc_step = 1'b1;
                    end
                end
            end
            S_EMIT_DENSE: begin
                if (desc_ready) begin
                    acc_step = 1'b1;
                    idx_d    = idx_q + 4'd1;
                    if (DW'(idx_q) + DW'(2) == n_q) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign acc_mode = (state_q == S_EMIT_DENSE);
    assign acc_a    = acc_load ? ld_val : desc_count;
    assign acc_b    = desc_aux;

    layer_base_acc #(.DW(DW)) u_acc (
        .clk   (clk),
        .RST_n (RST_n),
        .mode  (acc_mode),
        .fs    (fs_q),
        .a     (acc_a),
        .b     (acc_b),
        .load  (acc_load),
        .step  (acc_step),
        .base  (acc_base)
    );

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            idx_q   <= '0;
            fs_q    <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            fs_q    <= fs_d;
            n_q     <= n_d;
        end
    end

    always_ff @(posedge clk) begin
        if (hdr_we) hdr_q[k_q] <= ramDataOut;
    end

    assign readSignal  = (state_q == S_FETCH);
    assign ramAddress  = AW'(k_q);
    assign busy        = (state_q == S_FETCH) || (state_q == S_CAPT) || (state_q == S_CHECK) ||
                         (state_q == S_EMIT_CONV) || (state_q == S_EMIT_DENSE);
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERR);
    assign filter_size = fs_q;
    assign num_layers  = n_q;

endmodule

// File: tb/tb_cnn_header_reader.sv
// Directed bench for cnn_header_reader: a small RAM model answers reads one cycle
// late, and each task checks one scenario against hand-computed descriptors.
module tb_cnn_header_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ramAddress;
    logic        readSignal;
    logic [15:0] ram_q = '0;
    logic        busy, done, error;
    logic [15:0] filter_size, num_layers;
    logic        desc_valid;
    logic        desc_ready = 1'b1;
    logic        desc_dense;
    logic [3:0]  desc_index;
    logic [15:0] desc_count, desc_aux, desc_base;

    always #5 clk = ~clk;

    cnn_header_reader #(.MAX_LAYERS(10), .AW(16), .DW(16)) dut (
        .clk         (clk),
        .RST_n       (rst_n),
        .start       (start),
        .ramAddress  (ramAddress),
        .readSignal  (readSignal),
        .ramDataOut  (ram_q),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .filter_size (filter_size),
        .num_layers  (num_layers),
        .desc_valid  (desc_valid),
        .desc_ready  (desc_ready),
        .desc_dense  (desc_dense),
        .desc_index  (desc_index),
        .desc_count  (desc_count),
        .desc_aux    (desc_aux),
        .desc_base   (desc_base)
    );

    logic [15:0] mem [64];
    int rd_count = 0;
    int rd_high  = 0;

    always @(posedge clk) begin
        if (readSignal) begin
            ram_q <= mem[ramAddress[5:0]];
            rd_count++;
            if (ramAddress >= 16'd2) rd_high++;
        end
    end

    logic [105:0] all_out;
    assign all_out = {busy, done, error, desc_valid, desc_dense, desc_index, desc_count,
                      desc_aux, desc_base, readSignal, ramAddress, filter_size, num_layers};

    int total = 0;
    int passed = 0;

    logic [52:0] rec [16];
    int nrec, first_valid, first_read, cyc, stall_cnt, stall_bad, rd0, hi0;
    logic [15:0] first_addr;

    function automatic logic [52:0] pk(input logic d, input logic [3:0] i, input logic [15:0] c,
                                       input logic [15:0] a, input logic [15:0] b);
        return {d, i, c, a, b};
    endfunction

    task automatic load_mem(input int which);
        for (int i = 0; i < 64; i++) mem[i] = '0;
        if (which == 0) begin
            // fs=1 N=3 FO=14 DO=50, nf={6,6,6}, t={0,1,1}, pairs (12,12)x2
            mem[0] = 1;  mem[1] = 3;  mem[2] = 14; mem[3] = 50;
            mem[4] = 6;  mem[5] = 6;  mem[6] = 6;
            mem[7] = 0;  mem[8] = 1;  mem[9] = 1;
            mem[10] = 12; mem[11] = 12; mem[12] = 12; mem[13] = 12;
        end else if (which == 1) begin
            // fs=3 N=1 FO=6 DO=46, nf=4, t=2
            mem[0] = 3; mem[1] = 1; mem[2] = 6; mem[3] = 46; mem[4] = 4; mem[5] = 2;
        end else begin
            // fs=2 N=2 FO=10 DO=50, nf={3,5}, t={1,0}, pair (7,9)
            mem[0] = 2; mem[1] = 2; mem[2] = 10; mem[3] = 50;
            mem[4] = 3; mem[5] = 5; mem[6] = 1; mem[7] = 0; mem[8] = 7; mem[9] = 9;
        end
    endtask

    task automatic run_parse(input bit do_stall, input bit mid_start);
        rd0 = rd_count; hi0 = rd_high;
        nrec = 0; first_valid = -1; first_read = -1; first_addr = 16'hFFFF;
        stall_cnt = 0; stall_bad = 0;
        @(negedge clk); start = 1'b1; desc_ready = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 1;
        while (cyc < 400) begin
            if (mid_start) start = (cyc == 7);
            if (readSignal && first_read < 0) begin
                first_read = cyc;
                first_addr = ramAddress;
            end
            if (desc_valid && first_valid < 0) first_valid = cyc;
            desc_ready = 1'b1;
            if (do_stall && desc_valid && !desc_dense && desc_index == 4'd1 && stall_cnt < 5) begin
                desc_ready = 1'b0;
                stall_cnt++;
                if (desc_base !== 16'd26 || desc_count !== 16'd6) stall_bad++;
            end
            if (desc_valid && desc_ready && nrec < 16) begin
                rec[nrec] = pk(desc_dense, desc_index, desc_count, desc_aux, desc_base);
                nrec++;
            end
            if (done || error) break;
            @(negedge clk); cyc++;
        end
        start = 1'b0; desc_ready = 1'b1;
    endtask

    task automatic test_reset;
        #12;
        total++;
        if (all_out !== '0) $display("FAIL reset_held: got %h want 0", all_out);
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (all_out !== '0) $display("FAIL reset_idle: got %h want 0", all_out);
        else passed++;
        $display("test_reset: outputs after reset %h", all_out);
    endtask

    task automatic test_nominal;
        logic [52:0] ex [5];
        ex[0] = pk(0, 0, 6, 0, 14);  ex[1] = pk(0, 1, 6, 1, 26); ex[2] = pk(0, 2, 6, 1, 38);
        ex[3] = pk(1, 0, 12, 12, 50); ex[4] = pk(1, 1, 12, 12, 74);
        load_mem(0);
        run_parse(1'b0, 1'b0);
        $display("test_nominal: done=%0b error=%0b ndesc=%0d first_valid=%0d", done, error, nrec, first_valid);
        total++;
        if ({done, error} !== 2'b10) $display("FAIL nominal_status: done/error %b want 10", {done, error});
        else passed++;
        total++;
        if (nrec != 5) $display("FAIL nominal_count: got %0d descriptors want 5", nrec);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rec[i] !== ex[i]) $display("FAIL nominal_desc%0d: got %h want %h", i, rec[i], ex[i]);
            else passed++;
        end
        total++;
        if (first_read != 1 || first_addr !== 16'd0)
            $display("FAIL nominal_first_read: cycle %0d addr %0d want cycle 1 addr 0", first_read, first_addr);
        else passed++;
        total++;
        if (first_valid != 30) $display("FAIL nominal_latency: got %0d want 30", first_valid);
        else passed++;
        total++;
        if (filter_size !== 16'd1 || num_layers !== 16'd3)
            $display("FAIL nominal_fields: fs=%0d n=%0d want 1 3", filter_size, num_layers);
        else passed++;
        @(negedge clk);
        total++;
        if ({desc_valid, readSignal, busy, done} !== 4'b0001)
            $display("FAIL nominal_idle_done: valid/read/busy/done %b want 0001", {desc_valid, readSignal, busy, done});
        else passed++;
    endtask

    task automatic test_backpressure;
        logic [52:0] ex [5];
        ex[0] = pk(0, 0, 6, 0, 14);  ex[1] = pk(0, 1, 6, 1, 26); ex[2] = pk(0, 2, 6, 1, 38);
        ex[3] = pk(1, 0, 12, 12, 50); ex[4] = pk(1, 1, 12, 12, 74);
        load_mem(0);
        run_parse(1'b1, 1'b1);
        $display("test_backpressure: stalls=%0d unstable=%0d ndesc=%0d done=%0b", stall_cnt, stall_bad, nrec, done);
        total++;
        if (stall_cnt != 5 || stall_bad != 0)
            $display("FAIL bp_hold: stalls %0d unstable %0d want 5 0", stall_cnt, stall_bad);
        else passed++;
        total++;
        if (nrec != 5 || done !== 1'b1) $display("FAIL bp_count: got %0d done %b want 5 1", nrec, done);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rec[i] !== ex[i]) $display("FAIL bp_desc%0d: got %h want %h", i, rec[i], ex[i]);
            else passed++;
        end
    endtask

    task automatic test_errors;
        int nv [4]  = '{0, 11, 3, 3};
        int fov [4] = '{14, 14, 15, 14};
        int dov [4] = '{50, 50, 50, 51};
        int erd [4] = '{2, 2, 14, 14};
        int ehi [4] = '{0, 0, 12, 12};
        for (int c = 0; c < 4; c++) begin
            load_mem(0);
            mem[1] = 16'(nv[c]); mem[2] = 16'(fov[c]); mem[3] = 16'(dov[c]);
            run_parse(1'b0, 1'b0);
            $display("test_errors case %0d: error=%0b reads=%0d high=%0d ndesc=%0d",
                     c, error, rd_count - rd0, rd_high - hi0, nrec);
            total++;
            if ({error, done, busy} !== 3'b100)
                $display("FAIL err%0d_status: error/done/busy %b want 100", c, {error, done, busy});
            else passed++;
            total++;
            if (nrec != 0 || first_valid != -1)
                $display("FAIL err%0d_desc: got %0d descriptors want 0", c, nrec);
            else passed++;
            total++;
            if (rd_count - rd0 != erd[c] || rd_high - hi0 != ehi[c])
                $display("FAIL err%0d_reads: reads %0d high %0d want %0d %0d",
                         c, rd_count - rd0, rd_high - hi0, erd[c], ehi[c]);
            else passed++;
        end
    endtask

    task automatic test_single_layer;
        load_mem(1);
        run_parse(1'b0, 1'b0);
        $display("test_single_layer: done=%0b ndesc=%0d desc0=%h", done, nrec, rec[0]);
        total++;
        if ({done, error} !== 2'b10 || nrec != 1)
            $display("FAIL single_status: done/error %b ndesc %0d want 10 1", {done, error}, nrec);
        else passed++;
        total++;
        if (rec[0] !== pk(0, 0, 4, 2, 6)) $display("FAIL single_desc: got %h want %h", rec[0], pk(0, 0, 4, 2, 6));
        else passed++;
        total++;
        if (filter_size !== 16'd3 || num_layers !== 16'd1)
            $display("FAIL single_fields: fs=%0d n=%0d want 3 1", filter_size, num_layers);
        else passed++;
    endtask

    task automatic test_restart;
        logic [52:0] ex [3];
        ex[0] = pk(0, 0, 3, 1, 10); ex[1] = pk(0, 1, 5, 0, 25); ex[2] = pk(1, 0, 7, 9, 50);
        load_mem(2);
        run_parse(1'b0, 1'b0);
        $display("test_restart: done=%0b ndesc=%0d fs=%0d n=%0d", done, nrec, filter_size, num_layers);
        total++;
        if ({done, error} !== 2'b10 || nrec != 3)
            $display("FAIL restart_status: done/error %b ndesc %0d want 10 3", {done, error}, nrec);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rec[i] !== ex[i]) $display("FAIL restart_desc%0d: got %h want %h", i, rec[i], ex[i]);
            else passed++;
        end
        total++;
        if (filter_size !== 16'd2 || num_layers !== 16'd2)
            $display("FAIL restart_fields: fs=%0d n=%0d want 2 2", filter_size, num_layers);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int w;
        logic [52:0] ex [5];
        ex[0] = pk(0, 0, 6, 0, 14);  ex[1] = pk(0, 1, 6, 1, 26); ex[2] = pk(0, 2, 6, 1, 38);
        ex[3] = pk(1, 0, 12, 12, 50); ex[4] = pk(1, 1, 12, 12, 74);
        load_mem(0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        w = 0;
        while (!(readSignal && ramAddress == 16'd5) && w < 100) begin
            @(negedge clk); w++;
        end
        total++;
        if (w >= 100) $display("FAIL midrst_reach: fetch of word 5 not seen, got timeout want addr 5");
        else passed++;
        rst_n = 1'b0;
        #1;
        $display("test_reset_mid: outputs during reset %h", all_out);
        total++;
        if (all_out !== '0) $display("FAIL midrst_clear: got %h want 0", all_out);
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        run_parse(1'b0, 1'b0);
        total++;
        if ({done, error} !== 2'b10 || nrec != 5 || first_addr !== 16'd0)
            $display("FAIL midrst_replay: done/error %b ndesc %0d addr0 %0d want 10 5 0",
                     {done, error}, nrec, first_addr);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rec[i] !== ex[i]) $display("FAIL midrst_desc%0d: got %h want %h", i, rec[i], ex[i]);
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_backpressure;
        test_errors;
        test_single_layer;
        test_restart;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
